fib_bcd_conv: RTL and testbench
===============================

Name: fib_bcd_conv

Overview:
Downstream stage of the fibonacci block. It captures the 20-bit binary result whenever that block's out_en rises. It converts the value to packed BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock. The 7-digit BCD value then goes to a display/print stage with a one-cycle valid pulse.

Parameters:
WIDTH, 20, binary input width (matches fibonacci result width).
DIGITS, 7, BCD digit count; must satisfy 10^DIGITS > 2^WIDTH (7 covers 1048575).

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
result_in  input  WIDTH  binary value from fibonacci.result.
in_valid  input  1  fibonacci.out_en; level or pulse, a conversion starts only on a sampled rising edge.
bcd_out  output  4*DIGITS  packed BCD, digit 0 in [3:0]; holds the last completed conversion.
out_valid  output  1  one-cycle pulse when bcd_out is updated.
busy  output  1  high while converting.
drop  output  1  one-cycle pulse when a rising edge of in_valid is ignored because busy.

Behaviour:
- Reset (reset=0, async): state=IDLE; bcd_out=0; out_valid=0; busy=0; drop=0; bit counter=0; shift register=0; in_valid_d=0.
- Edge detect: in_valid_d registers in_valid each cycle. start_edge = in_valid & ~in_valid_d.
- Because in_valid_d resets to 0, an in_valid held high at reset release counts as an edge on the first active clock. This is intended.
- FSM IDLE:
  - On start_edge, load bin_sr=result_in and bcd_sr=0, clear the counter, set busy=1, go to SHIFT.
  - This clock is edge E0.
- FSM SHIFT, each clock (E1..E20):
  - First, every BCD nibble >=5 gets +3; nibbles are 4-bit and no carry passes between them.
  - Then {bcd_sr,bin_sr} shifts left by 1.
  - The counter increments.
- On the WIDTH-th shift (E20): bcd_out gets the final bcd_sr value, out_valid=1 for exactly one cycle, busy=0, state goes to IDLE.
- Latency: out_valid and the new bcd_out are visible after edge E0+WIDTH, which is 20 clocks after the capture edge. Throughput is one conversion per 21 clocks minimum.
- result_in is sampled only at E0. Later changes have no effect on the running conversion.
- A start_edge sampled at E1..E20 (state SHIFT, including the completing edge E20) is ignored. drop pulses for 1 cycle and the running conversion is unaffected.
- A start_edge sampled at E21 or later is accepted normally.
- bcd_out holds its value between conversions and changes only on completion.
- reset asserted mid-conversion: everything returns to reset values at once, no out_valid is generated, and the partial result is discarded.
- Counter width is clog2(WIDTH+1). Internal bcd_sr width is 4*DIGITS. Bits shifted beyond the top digit cannot occur for legal parameters.

Test Plan:
- Reset, then result_in=143 with an in_valid pulse 1 cycle wide (fibonacci nth=10) -> out_valid pulse exactly 20 clocks after the capture edge, bcd_out=0x0000143, busy high for those 20 cycles.
- Back-to-back requests 1 then 12 (nth=1, nth=5), each pulsed after the previous out_valid -> bcd_out=0x0000001, then 0x0000012, exactly one out_valid per request.
- result_in=1048575 and result_in=0, each sent as one request -> bcd_out=0x1048575 and 0x0000000 respectively (checks max and zero edge cases, add-3 on every nibble).
- in_valid held high for 50 clocks with result_in=987 -> exactly one conversion, bcd_out=0x0000987, no drop pulse.
- Second rising edge (result_in=55) 5 clocks after a 143 capture, and a third edge at E20 -> drop pulses twice, bcd_out=0x0000143, no second out_valid until a later edge at >=E21 gives 0x0000055.
- reset asserted at E10 of a 143 conversion -> bcd_out=0, busy=0, no out_valid. After release, a request of 21 gives 0x0000021 with normal latency.

Source files
------------

// File: rtl/fib_bcd_conv.sv
// Captures a binary result on the rising edge of in_valid and converts it to packed BCD
// with a bit-serial shift-add-3 engine, one bit per clock.
module fib_bcd_conv #(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      result_in,
    input  logic                  in_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  drop
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state_reg, state_next;
    logic                  in_valid_d_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [WIDTH-1:0]      bin_sr_reg;
    logic [4*DIGITS-1:0]   bcd_sr_reg;
    logic [4*DIGITS-1:0]   bcd_out_reg;
    logic                  out_valid_reg;
    logic                  drop_reg;

    logic                  start_edge;
    logic                  last_shift;
    logic [4*DIGITS-1:0]   bcd_adj;
    logic [4*DIGITS-1:0]   bcd_shift;
    logic [WIDTH-1:0]      bin_shift;

    assign start_edge = in_valid & ~in_valid_d_reg;
    assign last_shift = (state_reg == SHIFT) && (cnt_reg == LAST_CNT);

    // Per-digit add-3 correction; nibbles are independent, no carry between them.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            logic [3:0] nib;
            assign nib = bcd_sr_reg[4*gi +: 4];
            assign bcd_adj[4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    endgenerate

    assign bcd_shift = (bcd_adj << 1) | (4*DIGITS)'(bin_sr_reg[WIDTH-1]);
    assign bin_shift = bin_sr_reg << 1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_edge) state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == SHIFT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_valid_d_reg <= 1'b0;
            cnt_reg        <= '0;
            bin_sr_reg     <= '0;
            bcd_sr_reg     <= '0;
            bcd_out_reg    <= '0;
            out_valid_reg  <= 1'b0;
            drop_reg       <= 1'b0;
        end else begin
            in_valid_d_reg <= in_valid;
            out_valid_reg  <= 1'b0;
            // An edge arriving mid-conversion (including the completing clock) is discarded.
            drop_reg       <= start_edge && (state_reg == SHIFT);
            case (state_reg)
                IDLE: begin
                    if (start_edge) begin
                        bin_sr_reg <= result_in;
                        bcd_sr_reg <= '0;
                        cnt_reg    <= '0;
                    end
                end
                SHIFT: begin
                    bin_sr_reg <= bin_shift;
                    bcd_sr_reg <= bcd_shift;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (last_shift) begin
                        bcd_out_reg   <= bcd_shift;
                        out_valid_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bcd_out   = bcd_out_reg;
    assign out_valid = out_valid_reg;
    assign drop      = drop_reg;

endmodule

// File: tb/tb_fib_bcd_conv.sv
// Directed bench for fib_bcd_conv: latency, edge detection, drop handling and
// mid-conversion reset, with hand-computed BCD expectations.
module tb_fib_bcd_conv;

    localparam int WIDTH  = 20;
    localparam int DIGITS = 7;

    logic                clk;
    logic                reset;
    logic [WIDTH-1:0]    result_in;
    logic                in_valid;
    logic [4*DIGITS-1:0] bcd_out;
    logic                out_valid;
    logic                busy;
    logic                drop;

    int n_total;
    int n_bad;
    int ov_cnt;
    int drop_cnt;
    int busy_cnt;

    fib_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .result_in (result_in),
        .in_valid  (in_valid),
        .bcd_out   (bcd_out),
        .out_valid (out_valid),
        .busy      (busy),
        .drop      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) ov_cnt++;
        if (drop) drop_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One-cycle pulse; the capture edge E0 is the posedge inside this task.
    task automatic start_pulse(input logic [WIDTH-1:0] val);
        @(negedge clk);
        result_in = val;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Counts clocks after E0 until out_valid shows; bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) lat = 99;
    endtask

    int lat;
    int ov0;
    int dr0;

    initial begin
        n_total = 0; n_bad = 0; ov_cnt = 0; drop_cnt = 0; busy_cnt = 0;
        reset = 1'b0; in_valid = 1'b0; result_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_bcd", 32'(bcd_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ovalid", 32'(out_valid), 32'h0);
        chk("rst_drop", 32'(drop), 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 143 with latency and busy width
        ov0 = ov_cnt; dr0 = drop_cnt; busy_cnt = 0;
        start_pulse(20'd143);
        wait_done(lat);
        chk("lat_143", 32'(lat), 32'd20);
        chk("bcd_143", 32'(bcd_out), 32'h0000143);
        repeat (3) @(negedge clk);
        chk("busy_cycles_143", 32'(busy_cnt), 32'd20);
        chk("ovcnt_143", 32'(ov_cnt - ov0), 32'd1);

        // back-to-back 1 then 12
        ov0 = ov_cnt;
        start_pulse(20'd1);
        wait_done(lat);
        chk("lat_1", 32'(lat), 32'd20);
        chk("bcd_1", 32'(bcd_out), 32'h0000001);
        start_pulse(20'd12);
        wait_done(lat);
        chk("lat_12", 32'(lat), 32'd20);
        chk("bcd_12", 32'(bcd_out), 32'h0000012);
        repeat (3) @(negedge clk);
        chk("ovcnt_b2b", 32'(ov_cnt - ov0), 32'd2);

        // max and zero
        start_pulse(20'd1048575);
        wait_done(lat);
        chk("bcd_max", 32'(bcd_out), 32'h1048575);
        start_pulse(20'd0);
        wait_done(lat);
        chk("bcd_zero", 32'(bcd_out), 32'h0000000);
        chk("drop_none_so_far", 32'(drop_cnt - dr0), 32'd0);

        // level held high for 50 clocks
        repeat (2) @(negedge clk);
        ov0 = ov_cnt; dr0 = drop_cnt;
        result_in = 20'd987;
        in_valid  = 1'b1;
        repeat (50) @(negedge clk);
        in_valid  = 1'b0;
        repeat (3) @(negedge clk);
        chk("bcd_987", 32'(bcd_out), 32'h0000987);
        chk("ovcnt_held", 32'(ov_cnt - ov0), 32'd1);
        chk("drop_held", 32'(drop_cnt - dr0), 32'd0);

        // drops at E5 and E20, later edge accepted
        ov0 = ov_cnt; dr0 = drop_cnt;
        start_pulse(20'd143);          // now just after E0
        repeat (4) @(negedge clk);     // after E4
        result_in = 20'd55;
        in_valid  = 1'b1;              // sampled at E5
        @(negedge clk);
        in_valid  = 1'b0;
        repeat (14) @(negedge clk);    // after E19
        in_valid  = 1'b1;              // sampled at E20
        @(posedge clk);
        #1;
        chk("ovalid_at_e20", 32'(out_valid), 32'h1);
        chk("bcd_143_kept", 32'(bcd_out), 32'h0000143);
        @(negedge clk);
        in_valid  = 1'b0;
        repeat (5) @(negedge clk);
        chk("drop_twice", 32'(drop_cnt - dr0), 32'd2);
        chk("ovcnt_drop", 32'(ov_cnt - ov0), 32'd1);
        start_pulse(20'd55);
        wait_done(lat);
        chk("lat_55", 32'(lat), 32'd20);
        chk("bcd_55", 32'(bcd_out), 32'h0000055);

        // reset at E10 of a 143 conversion
        repeat (2) @(negedge clk);
        start_pulse(20'd143);
        repeat (9) @(negedge clk);
        @(posedge clk);                // E10
        #1;
        ov0 = ov_cnt;
        reset = 1'b0;
        #1;
        chk("midrst_bcd", 32'(bcd_out), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        chk("midrst_no_ovalid", 32'(ov_cnt - ov0), 32'd0);
        chk("midrst_bcd_hold", 32'(bcd_out), 32'h0);
        start_pulse(20'd21);
        wait_done(lat);
        chk("lat_21", 32'(lat), 32'd20);
        chk("bcd_21", 32'(bcd_out), 32'h0000021);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
